sm83_idu_seq: RTL



---
 rtl/sm83_idu_seq_if.sv | 23 ++
 rtl/sm83_idu_seq.sv | 104 ++++++++++
 2 files changed

// File: rtl/sm83_idu_seq_if.sv
// Request/result bundle between the register-file address bus and the SM83 IDU sequencer.
interface sm83_idu_seq_if;
    localparam int unsigned AW = 16;

    logic          start;
    logic          dec;
    logic [AW-1:0] addr_in;
    logic          ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr_out;
    logic          wrap;

    modport master (
        output start, dec, addr_in,
        input  ready, busy, done, addr_out, wrap
    );

    modport slave (
        input  start, dec, addr_in,
        output ready, busy, done, addr_out, wrap
    );
endinterface

// File: rtl/sm83_idu_seq.sv
// Byte-serial 16-bit increment/decrement: low byte first, high byte only on carry/borrow
// (or always, when SKIP_HIGH=0, for fixed latency).
module sm83_idu_seq #(
    parameter bit SKIP_HIGH = 1'b1
) (
    input logic           clk,
    input logic           reset,
    sm83_idu_seq_if.slave bus
);
    localparam int unsigned AW = 16;
    localparam int unsigned BW = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          dec_q, dec_d;
    logic          carry_q, carry_d;
    logic          wrap_q, wrap_d;
    logic          ready_q, busy_q, done_q;

    logic [BW-1:0] lo_c, hi_c;
    logic [BW-1:0] lo_nxt_c, hi_nxt_c;

    assign lo_c     = addr_q[BW-1:0];
    assign hi_c     = addr_q[AW-1:BW];
    assign lo_nxt_c = dec_q ? (lo_c - BW'(1)) : (lo_c + BW'(1));
    assign hi_nxt_c = dec_q ? (hi_c - BW'(carry_q)) : (hi_c + BW'(carry_q));

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dec_d   = dec_q;
        carry_d = carry_q;
        wrap_d  = wrap_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.addr_in;
                    dec_d   = bus.dec;
                    carry_d = 1'b0;
                    wrap_d  = 1'b0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                addr_d[BW-1:0] = lo_nxt_c;
                carry_d = (!dec_q && lo_c == 8'hFF) || (dec_q && lo_c == 8'h00);
                if (carry_d || !SKIP_HIGH) begin
                    state_d = S_HIGH;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_HIGH: begin
                addr_d[AW-1:BW] = hi_nxt_c;
                wrap_d  = carry_q && ((!dec_q && hi_c == 8'hFF) || (dec_q && hi_c == 8'h00));
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and status registers; status flags decode the next state so they track state_q
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            dec_q   <= 1'b0;
            carry_q <= 1'b0;
            wrap_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dec_q   <= dec_d;
            carry_q <= carry_d;
            wrap_q  <= wrap_d;
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d == S_LOW) || (state_d == S_HIGH);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.addr_out = addr_q;
    assign bus.wrap     = wrap_q;
endmodule
